turn_signal_ctrl: RTL and testbench
===================================

# turn_signal_ctrl

Sequencing controller for the tail-light pattern executor. It synchronises the left, right and hazard switch inputs and resolves them by priority into the 3-bit pattern select. It also generates the slow `clock_led` that steps the executor. Pattern changes are committed only at sequence boundaries, so a running left or right sweep is never truncated mid-pattern.

## Interface
- `DIV`, default 25000000: system-clock cycles per `clock_led` half-period. Must be at least 2. The counter width is $clog2(DIV).
- `MAX_SEQ`, default 8: number of complete turn sequences before auto-cancel. Used only with `TURN_TIMEOUT_EN`. Must be at least 1.
- `clock`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `sw_left`, input, 1: left switch. Asynchronous, level.
- `sw_right`, input, 1: right switch. Asynchronous, level.
- `sw_hazard`, input, 1: hazard switch. Asynchronous, level.
- `clock_led`, output, 1: square wave with period 2·DIV `clock` cycles. Drives the executor clock.
- `state_select`, output, 3: pattern select. 000 is idle, 001 is hazard, 010 is left, 011 is right. No other codes are ever driven.
- `phase`, output, 2: mirror of the executor's internal step counter.
- `active`, output, 1: 1 whenever `state_select` is not 000.

## Operation
- **Synchroniser:** each switch passes through a 2-flop synchroniser. The synchronised values are `l`, `r` and `h`.
- **Request resolution (combinational on synchronised values):**
  - HAZ if `h`, or if both `l` and `r` are set.
  - Otherwise LEFT if `l`.
  - Otherwise RIGHT if `r`.
  - Otherwise IDLE.
- **Divider:**
  - `div_cnt` counts 0 to DIV-1 and wraps.
  - On wrap, `clock_led` toggles.
  - A "rise" is the cycle in which `clock_led` goes 0→1. A "fall" is the cycle in which it goes 1→0.
- **Phase (updated on rise):**
  - Forced to 0 if `state_select` is IDLE.
  - Otherwise increments modulo 4. 3 wraps to 0.
- **State machine:** states IDLE, HAZ, LEFT, RIGHT, held in the `state_select` register. Transitions are evaluated only on fall cycles, giving the executor half a `clock_led` period of setup before its next rising edge.
  - From IDLE: go to the resolved request immediately.
  - Any state to HAZ: taken immediately when HAZ is requested.
  - From LEFT, RIGHT or HAZ to any non-HAZ target (including IDLE): taken only when `phase`==0. Otherwise the current state is held.
  - A request that goes away before the boundary is not latched. The target is re-evaluated at every fall.
- **Reset:** takes effect regardless of `clock`, including mid-sequence. The executor then sees IDLE at its next edge.

## Timing
- **Reset values:** `clock_led`=0, `state_select`=000, `phase`=00, `active`=0, `div_cnt`=0, synchronisers=0.
- **Divider after reset release:**
  - First rise occurs after DIV cycles.
  - First fall occurs after 2·DIV cycles.
  - Steady-state period is 2·DIV cycles.
- **Switch latency:**
  - 2 cycles through the synchroniser.
  - Then up to one full `clock_led` period waiting for a fall.
  - Then, for non-HAZ exits, up to 4 periods waiting for `phase`==0.
- **`state_select` and `active`:** both change only on fall cycles (and on reset). They are registered with no combinational path from the switches.
- **Simultaneous events:** on a fall cycle, the transition uses the `phase` value registered at the preceding rise.

## Configuration
- **`TURN_TIMEOUT_EN` defined:**
  - A 4-bit-minimum sequence counter increments at each rise where `phase` wraps 3→0 while in LEFT or RIGHT.
  - When the count reaches MAX_SEQ, the turn request is masked and the state leaves at the next boundary.
  - The mask clears only once the synchronised `l` and `r` are both 0.
  - The count clears on any state change and on reset.
  - HAZ is never masked.
- **`TURN_TIMEOUT_EN` undefined:** no counter and no mask. LEFT or RIGHT persists for as long as the switch is held.

## Test plan
All scenarios use DIV=4, giving a `clock_led` period of 8 cycles.
- **Reset:** assert `reset` mid-period with the counter running → all outputs 0 asynchronously. After release, first `clock_led` rise at cycle 4.
- **Left from idle:** hold `sw_left` from cycle 0 → `state_select`=010 at the first fall (cycle 8). `phase` then steps 1,2,3,0 on rises at cycles 12, 20, 28, 36.
- **Left to right:** `sw_left` is held until `phase`=1, then `sw_right` is asserted and `sw_left` dropped → `state_select` stays 010 until the fall that follows `phase` reaching 0, then becomes 011. No 000 appears in between.
- **Hazard preemption:** in RIGHT at `phase`=2, assert `sw_hazard` → `state_select`=001 at the next fall, without waiting for a boundary. `sw_left` plus `sw_right` together also give 001.
- **Release to idle:** drop all switches while in LEFT → `state_select` holds 010 until `phase`=0, then becomes 000 at that fall. `active`=0 and `phase` is held at 0.
- **Timeout (`TURN_TIMEOUT_EN`, MAX_SEQ=2):** hold `sw_left` → after 2 full sequences, `state_select`=000. It re-enters 010 only after `sw_left` is released and reasserted.

Source files
------------

// File: rtl/turn_signal_ctrl.sv
// ============================================================================
// Module   : turn_signal_ctrl
// Brief    : Tail-light sequencing controller: switch sync, priority resolve,
//            slow LED clock and boundary-aligned pattern select.
//            Optional turn auto-cancel enabled by macro TURN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_signal_ctrl #(
    parameter int DIV     = 25000000,
    parameter int MAX_SEQ = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       sw_hazard,
    output logic       clock_led,
    output logic [2:0] state_select,
    output logic [1:0] phase,
    output logic       active
);

    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        HAZ   = 3'b001,
        LEFT  = 3'b010,
        RIGHT = 3'b011
    } state_t;

    state_t        state;
    state_t        state_next;
    state_t        target;

    logic [1:0]    sync_l;
    logic [1:0]    sync_r;
    logic [1:0]    sync_h;
    logic          l;
    logic          r;
    logic          h;
    logic          turn_l;
    logic          turn_r;

    logic [CW-1:0] div_cnt;
    logic          wrap;
    logic          rise;
    logic          fall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_l <= 2'b00;
            sync_r <= 2'b00;
            sync_h <= 2'b00;
        end else begin
            sync_l <= {sync_l[0], sw_left};
            sync_r <= {sync_r[0], sw_right};
            sync_h <= {sync_h[0], sw_hazard};
        end
    end

    assign l = sync_l[1];
    assign r = sync_r[1];
    assign h = sync_h[1];

    assign wrap = (div_cnt == DIV_LAST);
    assign rise = wrap & ~clock_led;
    assign fall = wrap &  clock_led;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            clock_led <= 1'b0;
        end else if (wrap) begin
            div_cnt   <= '0;
            clock_led <= ~clock_led;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= 2'b00;
        end else if (rise) begin
            phase <= (state == IDLE) ? 2'b00 : phase + 2'b01;
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int            SW      = ($clog2(MAX_SEQ + 1) > 4) ? $clog2(MAX_SEQ + 1) : 4;
    localparam logic [SW-1:0] SEQ_MAX = SW'(MAX_SEQ);

    logic [SW-1:0] seq_cnt;
    logic          mask;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_cnt <= '0;
        end else if (fall && (state_next != state)) begin
            seq_cnt <= '0;
        end else if (rise && (phase == 2'b11) && ((state == LEFT) || (state == RIGHT))
                     && (seq_cnt < SEQ_MAX)) begin
            seq_cnt <= seq_cnt + 1'b1;
        end
    end

    // Mask outlives the counter: it only drops once both turn switches are off.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask <= 1'b0;
        end else if (seq_cnt >= SEQ_MAX) begin
            mask <= 1'b1;
        end else if (!l && !r) begin
            mask <= 1'b0;
        end
    end

    assign turn_l = l & ~mask & ~(seq_cnt >= SEQ_MAX);
    assign turn_r = r & ~mask & ~(seq_cnt >= SEQ_MAX);
`else
    assign turn_l = l;
    assign turn_r = r;
`endif

    always_comb begin
        target = IDLE;
        if (h || (l && r)) begin
            target = HAZ;
        end else if (turn_l) begin
            target = LEFT;
        end else if (turn_r) begin
            target = RIGHT;
        end
    end

    // Non-hazard exits wait for the executor to finish its sweep (phase 0).
    always_comb begin
        state_next = state;
        if (fall) begin
            if ((state == IDLE) || (target == HAZ)) begin
                state_next = target;
            end else if ((target != state) && (phase == 2'b00)) begin
                state_next = target;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign state_select = state;
    assign active       = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_turn_signal_ctrl.sv
// ============================================================================
// Module   : tb_turn_signal_ctrl
// Brief    : Directed vector bench for turn_signal_ctrl with DIV=4, MAX_SEQ=2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_turn_signal_ctrl;

    localparam int DIV     = 4;
    localparam int MAX_SEQ = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sw_left = 1'b0;
    logic       sw_right = 1'b0;
    logic       sw_hazard = 1'b0;
    logic       clock_led;
    logic [2:0] state_select;
    logic [1:0] phase;
    logic       active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    turn_signal_ctrl #(.DIV(DIV), .MAX_SEQ(MAX_SEQ)) dut (
        .clock       (clock),
        .reset       (reset),
        .sw_left     (sw_left),
        .sw_right    (sw_right),
        .sw_hazard   (sw_hazard),
        .clock_led   (clock_led),
        .state_select(state_select),
        .phase       (phase),
        .active      (active)
    );

    always #5 clock = ~clock;

    // Rising edges since reset release.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int         cyc;
        logic       l;
        logic       r;
        logic       h;
        logic [2:0] sel;
        logic [1:0] ph;
        logic       led;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int c, input logic l, input logic r, input logic h,
                       input logic [2:0] sel, input logic [1:0] ph, input logic led);
        vec_t v;
        v.cyc = c; v.l = l; v.r = r; v.h = h; v.sel = sel; v.ph = ph; v.led = led;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int c, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    task automatic chk_all(input int c, input logic [2:0] sel, input logic [1:0] ph,
                           input logic led);
        chk("state_select", c, int'(state_select), int'(sel));
        chk("phase",        c, int'(phase),        int'(ph));
        chk("clock_led",    c, int'(clock_led),    int'(led));
        chk("active",       c, int'(active),       int'(sel != 3'b000));
    endtask

    // Sample 1 time unit after the n-th post-release edge.
    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 2000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL goto: reached cyc %0d expected %0d", cyc, n);
        end
    endtask

    task automatic drive(input logic l, input logic r, input logic h);
        sw_left   = l;
        sw_right  = r;
        sw_hazard = h;
    endtask

    initial begin
        //   cyc  l  r  h   sel     ph     led
        add(  0, 1, 0, 0, 3'b000, 2'd0, 1'b0);
        add(  3, 1, 0, 0, 3'b000, 2'd0, 1'b0);
        add(  4, 1, 0, 0, 3'b000, 2'd0, 1'b1);
        add(  7, 1, 0, 0, 3'b000, 2'd0, 1'b1);
        add(  8, 1, 0, 0, 3'b010, 2'd0, 1'b0);
        add( 12, 1, 0, 0, 3'b010, 2'd1, 1'b1);
        add( 16, 0, 1, 0, 3'b010, 2'd1, 1'b0);
        add( 20, 0, 1, 0, 3'b010, 2'd2, 1'b1);
        add( 28, 0, 1, 0, 3'b010, 2'd3, 1'b1);
        add( 36, 0, 1, 0, 3'b010, 2'd0, 1'b1);
        add( 39, 0, 1, 0, 3'b010, 2'd0, 1'b1);
        add( 40, 0, 1, 0, 3'b011, 2'd0, 1'b0);
        add( 44, 0, 1, 0, 3'b011, 2'd1, 1'b1);
        add( 52, 0, 1, 1, 3'b011, 2'd2, 1'b1);
        add( 55, 0, 1, 1, 3'b011, 2'd2, 1'b1);
        add( 56, 1, 1, 0, 3'b001, 2'd2, 1'b0);
        add( 60, 1, 1, 0, 3'b001, 2'd3, 1'b1);
        add( 64, 1, 0, 0, 3'b001, 2'd3, 1'b0);
        add( 71, 1, 0, 0, 3'b001, 2'd0, 1'b1);
        add( 72, 1, 0, 0, 3'b010, 2'd0, 1'b0);
        add( 76, 0, 0, 0, 3'b010, 2'd1, 1'b1);
        add( 96, 0, 0, 0, 3'b010, 2'd3, 1'b0);
        add(103, 0, 0, 0, 3'b010, 2'd0, 1'b1);
        add(104, 0, 0, 0, 3'b000, 2'd0, 1'b0);
        add(108, 1, 0, 0, 3'b000, 2'd0, 1'b1);

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            goto(tbl[i].cyc);
            chk_all(tbl[i].cyc, tbl[i].sel, tbl[i].ph, tbl[i].led);
            drive(tbl[i].l, tbl[i].r, tbl[i].h);
        end

        // Asynchronous reset in the middle of a running LEFT sweep.
        goto(112);
        chk_all(112, 3'b010, 2'd0, 1'b0);
        goto(117);
        chk_all(117, 3'b010, 2'd1, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk_all(-1, 3'b000, 2'd0, 1'b0);
        @(posedge clock);
        #1;
        chk_all(-2, 3'b000, 2'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // sw_left stays held through release: divider restarts from zero.
        goto(3);
        chk_all(3, 3'b000, 2'd0, 1'b0);
        goto(4);
        chk_all(4, 3'b000, 2'd0, 1'b1);
        goto(8);
        chk_all(8, 3'b010, 2'd0, 1'b0);

        // Two full sequences complete at the rise on cycle 68.
        goto(71);
        chk_all(71, 3'b010, 2'd0, 1'b1);
        goto(72);
`ifdef TURN_TIMEOUT_EN
        chk_all(72, 3'b000, 2'd0, 1'b0);
`else
        chk_all(72, 3'b010, 2'd0, 1'b0);
`endif
        drive(1'b0, 1'b0, 1'b0);
        goto(76);
        drive(1'b1, 1'b0, 1'b0);
        goto(79);
`ifdef TURN_TIMEOUT_EN
        chk_all(79, 3'b000, 2'd0, 1'b1);
`else
        chk_all(79, 3'b010, 2'd1, 1'b1);
`endif
        goto(80);
`ifdef TURN_TIMEOUT_EN
        chk_all(80, 3'b010, 2'd0, 1'b0);
`else
        chk_all(80, 3'b010, 2'd1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
